// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Board-level reset sequencer. Waits for the PLL to lock (and kicks the PLL
//   if it never does), requires lock to remain stable for a while before
//   releasing the system reset, waits for memory/peripheral initialisation
//   before releasing the CPU, and handles a debounced user reset button.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock, asynchronous (synchronized here)
//   reset_btn_n  in   user reset button, asynchronous, active-low (synchronized here)
//   init_done    in   initialisation-complete level
//   sys_reset    out  active-high peripheral reset (registered)
//   cpu_reset    out  active-high CPU reset (registered)
//   pll_reset    out  active-high PLL reset request (registered)
module reset_sequencer #(
  parameter int STABLE_CYCLES       = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 262144,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES     = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic reset_btn_n,
  input  logic init_done,
  output logic sys_reset,
  output logic cpu_reset,
  output logic pll_reset
);

  // One shared state counter; it only ever has to reach (longest limit - 1).
  localparam int MAX_A   = (STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_LIM = (MAX_A > PLL_RESET_CYCLES) ? MAX_A : PLL_RESET_CYCLES;
  localparam int CNT_W   = (CNT_LIM > 1) ? $clog2(CNT_LIM) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LTO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRC_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RST   = 3'd1,
    STABLE    = 3'd2,
    WAIT_INIT = 3'd3,
    RUN       = 3'd4,
    BTN_HOLD  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  logic             deb_lvl_q, deb_lvl_d;   // level the debounce counter is timing
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;   // consecutive cycles at deb_lvl, saturating
  logic             sys_reset_q, sys_reset_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             pll_reset_q, pll_reset_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             press, release_ok;

  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    btn_meta_d  = reset_btn_n;
    btn_s_d     = btn_meta_q;

    // Run length of the current synchronized button level, this cycle included.
    // Any change of level restarts the run at 1.
    deb_lvl_d = btn_s_q;
    if (btn_s_q != deb_lvl_q)      deb_cnt_d = DEB_W'(1);
    else if (deb_cnt_q == DEB_FULL) deb_cnt_d = deb_cnt_q;
    else                            deb_cnt_d = deb_cnt_q + DEB_W'(1);
    press      = !btn_s_q && (deb_cnt_d == DEB_FULL);
    release_ok =  btn_s_q && (deb_cnt_d == DEB_FULL);

    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q)              begin state_d = STABLE;  cnt_d = '0; end
        else if (cnt_q == LTO_LAST) begin state_d = PLL_RST; cnt_d = '0; end
        else                        cnt_d = cnt_inc;
      end
      PLL_RST: begin
        if (cnt_q == PRC_LAST) begin state_d = WAIT_LOCK; cnt_d = '0; end
        else                   cnt_d = cnt_inc;
      end
      STABLE: begin
        // Any dropout sends us back, so a glitch restarts the full count.
        if (!lock_s_q)              begin state_d = WAIT_LOCK; cnt_d = '0; end
        else if (press)             begin state_d = BTN_HOLD;  cnt_d = '0; end
        else if (cnt_q == STB_LAST) begin state_d = WAIT_INIT; cnt_d = '0; end
        else                        cnt_d = cnt_inc;
      end
      WAIT_INIT: begin
        if (!lock_s_q)      begin state_d = WAIT_LOCK; cnt_d = '0; end
        else if (press)     state_d = BTN_HOLD;
        else if (init_done) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q)  begin state_d = WAIT_LOCK; cnt_d = '0; end
        else if (press) state_d = BTN_HOLD;
      end
      BTN_HOLD: begin
        if (release_ok) begin state_d = WAIT_LOCK; cnt_d = '0; end
      end
      default: begin state_d = WAIT_LOCK; cnt_d = '0; end
    endcase

    // Outputs decoded from the next state so they change on the transition edge.
    sys_reset_d = !(state_d == WAIT_INIT || state_d == RUN);
    cpu_reset_d = (state_d != RUN);
    pll_reset_d = (state_d == PLL_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_meta_q  <= 1'b1;
      btn_s_q     <= 1'b1;
      deb_lvl_q   <= 1'b1;
      deb_cnt_q   <= '0;
      sys_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      pll_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      btn_meta_q  <= btn_meta_d;
      btn_s_q     <= btn_s_d;
      deb_lvl_q   <= deb_lvl_d;
      deb_cnt_q   <= deb_cnt_d;
      sys_reset_q <= sys_reset_d;
      cpu_reset_q <= cpu_reset_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign cpu_reset = cpu_reset_q;
  assign pll_reset = pll_reset_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before sys_reset release.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 262144, meaning cycles waited for lock before requesting a PLL reset.
REQ-003 The block SHALL have parameter PLL_RESET_CYCLES, default 16, meaning width in cycles of a pll_reset pulse.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive synchronized-low cycles that qualify a button press or release (10 ms at 25 MHz).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock (PLL 25 MHz output); all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port pll_locked, input, 1 bit, meaning the PLL lock indication, asynchronous to clk.
REQ-008 The block SHALL have port reset_btn_n, input, 1 bit, meaning the user reset button, asynchronous and active-low.
REQ-009 The block SHALL have port init_done, input, 1 bit, meaning a level from the memory/peripheral initialiser indicating initialisation is complete.
REQ-010 The block SHALL have port sys_reset, output, 1 bit, meaning the active-high system reset for peripherals.
REQ-011 The block SHALL have port cpu_reset, output, 1 bit, meaning the active-high CPU core reset.
REQ-012 The block SHALL have port pll_reset, output, 1 bit, meaning the active-high request to the PLL rst input.

Function
REQ-013 pll_locked and reset_btn_n SHALL each pass through a 2-flop synchronizer (lock_s, btn_s) before any use.
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states SHALL be: WAIT_LOCK, PLL_RST, STABLE, WAIT_INIT, RUN, BTN_HOLD.
REQ-016 In WAIT_LOCK: if lock_s=1, go to STABLE with cnt=0; else increment cnt; at cnt=LOCK_TIMEOUT_CYCLES-1, go to PLL_RST with cnt=0.
REQ-017 In PLL_RST: pll_reset=1 for exactly PLL_RESET_CYCLES cycles, then go to WAIT_LOCK with cnt=0; pll_reset=0 in all other states.
REQ-018 In STABLE: if lock_s=0, go to WAIT_LOCK with cnt=0; at cnt=STABLE_CYCLES-1 with lock_s=1, go to WAIT_INIT; otherwise increment cnt.
REQ-019 In WAIT_INIT: go to RUN when init_done=1.
REQ-020 Output table: sys_reset=1 in WAIT_LOCK, PLL_RST, STABLE, BTN_HOLD, else 0; cpu_reset=0 only in RUN; outputs take effect on the same edge as the state transition.
REQ-021 Lock loss (lock_s=0) in WAIT_INIT or RUN SHALL go to WAIT_LOCK, reasserting both resets on that edge.
REQ-022 A qualified press (btn_s=0 for DEBOUNCE_CYCLES consecutive cycles) in STABLE, WAIT_INIT or RUN SHALL go to BTN_HOLD.
REQ-023 In BTN_HOLD: go to WAIT_LOCK with cnt=0 after btn_s=1 for DEBOUNCE_CYCLES consecutive cycles.
REQ-024 Priority SHALL be: rst > lock loss > button > normal progression.
REQ-025 The debounce counter SHALL clear on any btn_s change.
REQ-026 All counters SHALL be sized $clog2 of their maximum and SHALL saturate, never wrap.
REQ-027 Timing from pll_locked rising with the sampling edge counted as edge 0: STABLE entered at edge 2, sys_reset falls at edge STABLE_CYCLES+2.
REQ-028 A lock_s glitch of any length during STABLE SHALL restart the full STABLE_CYCLES count.

Reset
REQ-029 On rst=1 at a clk edge: state=WAIT_LOCK, all counters=0, synchronizer flops cleared to lock_s=0 and btn_s=1, sys_reset=1, cpu_reset=1, pll_reset=0.
REQ-030 rst asserted mid-operation, including mid-PLL_RST, SHALL apply REQ-029 on that edge and truncate any pll_reset pulse.

Verification (bench parameters: STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, PLL_RESET_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-031 The bench SHALL cover: rst, then pll_locked=1 at edge 0, init_done=1 at edge 20 -> sys_reset falls at edge 10, cpu_reset falls at edge 21.
REQ-032 The bench SHALL cover: pll_locked held 0 -> pll_reset high for exactly 4 cycles after 32 WAIT_LOCK cycles, repeating every 36 cycles; sys_reset stays 1.
REQ-033 The bench SHALL cover: pll_locked drops for 1 cycle at STABLE cnt=5 -> count restarts, and sys_reset is released 8 full stable cycles after relock.
REQ-034 The bench SHALL cover: in RUN, pll_locked falls -> sys_reset and cpu_reset both high 3 edges later (2 sync + 1 state).
REQ-035 The bench SHALL cover: in RUN, a 3-cycle button-low bounce -> no effect; a 6-cycle low -> BTN_HOLD with both resets high; after release for 4 cycles -> WAIT_LOCK, then normal re-sequence.
REQ-036 The bench SHALL cover: rst pulsed during PLL_RST cycle 2 -> pll_reset=0 on the next edge, state WAIT_LOCK, cnt=0.
